// File: rtl/aes_inv_round_ctrl.sv
// Round sequencer for an iterative AES inverse cipher.
// Sequences the initial AddRoundKey, then NR issues to an external
// inverse-round datapath of fixed latency DP_LAT, and returns the plaintext.
// Optional abort input is present when AES_INV_ROUND_CTRL_ABORT_EN is defined.
module aes_inv_round_ctrl #(
  parameter int unsigned NR     = 10,
  parameter int unsigned DP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_in,
  output logic         dp_valid,
  output logic         dp_last,
  input  logic [127:0] dp_out,
  output logic         busy,
  output logic         done,
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] pt_out
);

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] R_FIRST  = 4'(NR - 1);
  localparam logic [2:0] LAT_LAST = 3'(DP_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t       fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] pt_q,  pt_d;
  logic [3:0]   r_q,   r_d;
  logic [2:0]   lat_q, lat_d;
  logic         abort_req;

`ifdef AES_INV_ROUND_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign pt_out = pt_q;

  // State register, working block, round and latency counters, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      blk_q <= '0;
      pt_q  <= '0;
      r_q   <= '0;
      lat_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      pt_q  <= pt_d;
      r_q   <= r_d;
      lat_q <= lat_d;
    end
  end

  // Next-state and output decode; datapath-facing outputs are held
  // from ISSUE through the end of WAIT since r and blk do not move there.
  always_comb begin
    fsm_d    = fsm_q;
    blk_d    = blk_q;
    pt_d     = pt_q;
    r_d      = r_q;
    lat_d    = lat_q;
    rk_idx   = '0;
    dp_in    = '0;
    dp_valid = 1'b0;
    dp_last  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = INIT;
          blk_d = ct_in;
        end
      end
      INIT: begin
        busy   = 1'b1;
        rk_idx = NR_IDX;
        blk_d  = blk_q ^ rk_data;
        r_d    = R_FIRST;
        fsm_d  = ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        rk_idx   = r_q;
        dp_in    = blk_q;
        dp_valid = 1'b1;
        dp_last  = (r_q == '0);
        lat_d    = '0;
        fsm_d    = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        rk_idx  = r_q;
        dp_in   = blk_q;
        dp_last = (r_q == '0);
        if (lat_q == LAT_LAST) begin
          blk_d = dp_out;
          if (r_q == '0) begin
            // Result is registered on entry to DONE so pt_out is valid with done.
            pt_d  = dp_out;
            fsm_d = DONE;
          end else begin
            r_d   = r_q - 4'd1;
            fsm_d = ISSUE;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    if (abort_req && (fsm_q == INIT || fsm_q == ISSUE || fsm_q == WAIT)) begin
      fsm_d = IDLE;
      pt_d  = pt_q;
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl: two instances (DP_LAT 1 and 3)
// share a behavioural key store and inverse-round datapath model.
// Abort sequences are included when AES_INV_ROUND_CTRL_ABORT_EN is defined.
module tb_aes_inv_round_ctrl;
  localparam int NR   = 10;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_s    [2];
  logic [127:0] ct_s       [2];
  logic [3:0]   rk_idx_s   [2];
  logic [127:0] rk_data_s  [2];
  logic [127:0] dp_in_s    [2];
  logic         dp_valid_s [2];
  logic         dp_last_s  [2];
  logic [127:0] dp_out_s   [2];
  logic         busy_s     [2];
  logic         done_s     [2];
  logic [127:0] pt_s       [2];
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
  logic         abort_s    [2];
`endif

  aes_inv_round_ctrl #(.NR(NR), .DP_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .ct_in(ct_s[0]),
    .rk_idx(rk_idx_s[0]), .rk_data(rk_data_s[0]), .dp_in(dp_in_s[0]),
    .dp_valid(dp_valid_s[0]), .dp_last(dp_last_s[0]), .dp_out(dp_out_s[0]),
    .busy(busy_s[0]), .done(done_s[0]),
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    .abort(abort_s[0]),
`endif
    .pt_out(pt_s[0])
  );

  aes_inv_round_ctrl #(.NR(NR), .DP_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .ct_in(ct_s[1]),
    .rk_idx(rk_idx_s[1]), .rk_data(rk_data_s[1]), .dp_in(dp_in_s[1]),
    .dp_valid(dp_valid_s[1]), .dp_last(dp_last_s[1]), .dp_out(dp_out_s[1]),
    .busy(busy_s[1]), .done(done_s[1]),
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    .abort(abort_s[1]),
`endif
    .pt_out(pt_s[1])
  );

  function automatic int lat_of(input int g);
    return (g == 0) ? LAT0 : LAT1;
  endfunction

  // ---------------- AES behavioural helpers ----------------
  logic [7:0]   sbox   [256];
  logic [7:0]   isbox  [256];
  logic [127:0] rk_mem [0:10];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j <= 10; j++) rk_mem[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = getb(s, i);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r+4*c] = isbox[a[r+4*((c-r+4)%4)]] ^ getb(k, r+4*c);
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = gmul(x0, 8'h0e) ^ gmul(x1, 8'h0b) ^ gmul(x2, 8'h0d) ^ gmul(x3, 8'h09);
        b[4*c+1] = gmul(x0, 8'h09) ^ gmul(x1, 8'h0e) ^ gmul(x2, 8'h0b) ^ gmul(x3, 8'h0d);
        b[4*c+2] = gmul(x0, 8'h0d) ^ gmul(x1, 8'h09) ^ gmul(x2, 8'h0e) ^ gmul(x3, 8'h0b);
        b[4*c+3] = gmul(x0, 8'h0b) ^ gmul(x1, 8'h0d) ^ gmul(x2, 8'h09) ^ gmul(x3, 8'h0e);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  // Full-block reference decryption with the current key schedule.
  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk_mem[10];
    for (int r = 9; r >= 0; r--) s = inv_round(s, rk_mem[r], r == 0);
    return s;
  endfunction

  // ---------------- key store and datapath model ----------------
  logic [127:0] pd [2][8];
  logic         pv [2][8];
  logic [127:0] garb;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      rk_data_s[g] = (rk_idx_s[g] <= 4'd10) ? rk_mem[rk_idx_s[g]] : '0;
      dp_out_s[g]  = pv[g][lat_of(g)-1] ? pd[g][lat_of(g)-1] : garb;
    end
  end

  always @(posedge clk) begin
    garb <= {$urandom, $urandom, $urandom, $urandom};
    for (int g = 0; g < 2; g++) begin
      pd[g][0] <= inv_round(dp_in_s[g], rk_data_s[g], dp_last_s[g]);
      pv[g][0] <= dp_valid_s[g] && !rst;
      for (int i = 1; i < 8; i++) begin
        pd[g][i] <= pd[g][i-1];
        pv[g][i] <= pv[g][i-1] && !rst;
      end
    end
  end

  // ---------------- interface monitor ----------------
  int           ncyc = 0;
  int           stab_err   [2] = '{0, 0};
  int           nvalid     [2] = '{0, 0};
  int           consec_err [2] = '{0, 0};
  int           seq_n      [2] = '{0, 0};
  int           wait_left  [2] = '{0, 0};
  logic [3:0]   seq_mem    [2][1024];
  logic         busy_prev  [2] = '{1'b0, 1'b0};
  logic         valid_prev [2] = '{1'b0, 1'b0};
  logic [127:0] snap_in    [2];
  logic [3:0]   snap_idx   [2];
  logic         snap_last  [2];

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      busy_prev[g]  <= busy_s[g];
      valid_prev[g] <= dp_valid_s[g];
      if (busy_s[g] && !busy_prev[g]) begin
        if (seq_n[g] < 1024) seq_mem[g][seq_n[g]] <= rk_idx_s[g];
        seq_n[g] <= seq_n[g] + 1;
      end else if (dp_valid_s[g]) begin
        if (seq_n[g] < 1024) seq_mem[g][seq_n[g]] <= rk_idx_s[g];
        seq_n[g]     <= seq_n[g] + 1;
        nvalid[g]    <= nvalid[g] + 1;
        if (valid_prev[g]) consec_err[g] <= consec_err[g] + 1;
        snap_in[g]   <= dp_in_s[g];
        snap_idx[g]  <= rk_idx_s[g];
        snap_last[g] <= dp_last_s[g];
        wait_left[g] <= lat_of(g);
      end else if (wait_left[g] != 0) begin
        if (busy_s[g] && (dp_in_s[g] != snap_in[g] || rk_idx_s[g] != snap_idx[g] ||
                          dp_last_s[g] != snap_last[g]))
          stab_err[g] <= stab_err[g] + 1;
        wait_left[g] <= wait_left[g] - 1;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input int g);
    chk("rst_busy",     128'(busy_s[g]),     '0);
    chk("rst_done",     128'(done_s[g]),     '0);
    chk("rst_dp_valid", 128'(dp_valid_s[g]), '0);
    chk("rst_dp_last",  128'(dp_last_s[g]),  '0);
    chk("rst_rk_idx",   128'(rk_idx_s[g]),   '0);
    chk("rst_dp_in",    dp_in_s[g],          '0);
    chk("rst_pt_out",   pt_s[g],             '0);
  endtask

  // Start one block at the current negedge (sampled on the next edge = cycle 0)
  // and follow it to completion; g1/g2 pulse start during the operation.
  task automatic run_op(input int g, input logic [127:0] ct, input logic [127:0] exp_pt,
                        input int g1, input int g2, output int done_abs);
    int cyc, lat, busy_n, want, nv0, se0, ce0, sq0, seqbad;
    logic [127:0] pt;
    want = 2 + NR * (lat_of(g) + 1);
    nv0 = nvalid[g]; se0 = stab_err[g]; ce0 = consec_err[g]; sq0 = seq_n[g];
    lat = 0; busy_n = 0; pt = '0; done_abs = 0;
    start_s[g] = 1'b1;
    ct_s[g]    = ct;
    @(negedge clk);
    start_s[g] = 1'b0;
    ct_s[g]    = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while (lat == 0 && cyc <= 200) begin
      start_s[g] = (cyc == g1) || (cyc == g2);
      if (done_s[g]) begin
        lat = cyc;
        pt  = pt_s[g];
        done_abs = ncyc;
        chk("busy_at_done",     128'(busy_s[g]),     '0);
        chk("rk_idx_at_done",   128'(rk_idx_s[g]),   '0);
        chk("dp_valid_at_done", 128'(dp_valid_s[g]), '0);
      end else if (busy_s[g]) begin
        busy_n++;
      end
      @(negedge clk);
      cyc++;
    end
    start_s[g] = 1'b0;
    chk("done_width",   128'(done_s[g]), '0);
    chk("pt_hold",      pt_s[g], exp_pt);
    chk("latency",      128'(lat), 128'(want));
    chk("pt_out",       pt, exp_pt);
    chk("busy_cycles",  128'(busy_n), 128'(want - 1));
    chk("issue_count",  128'(nvalid[g] - nv0), 128'(NR));
    chk("issue_consec", 128'(consec_err[g] - ce0), '0);
    chk("wait_stable",  128'(stab_err[g] - se0), '0);
    seqbad = (seq_n[g] - sq0 == NR + 1) ? 0 : 1;
    for (int i = 0; i <= NR && sq0 + i < 1024; i++)
      if (seq_mem[g][sq0+i] != 4'(NR - i)) seqbad++;
    chk("rk_idx_seq", 128'(seqbad), '0);
  endtask

  typedef struct {
    int           inst;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] KEY_F = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_F  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_F  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t         tbl [5];
    int           d1, d2, dn;
    logic [127:0] key, ct, exp_pt;
    int           g;

    tbl[0] = '{0, KEY_F, CT_F, PT_F};
    tbl[1] = '{1, KEY_F, CT_F, PT_F};
    tbl[2] = '{0, KEY_B, CT_B, PT_B};
    tbl[3] = '{1, KEY_B, CT_B, PT_B};
    tbl[4] = '{0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      ct_s[i]    = '0;
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
      abort_s[i] = 1'b0;
`endif
    end
    build_sbox();
    set_key(KEY_F);
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors on both datapath latencies.
    for (int i = 0; i < 5; i++) begin
      set_key(tbl[i].key);
      run_op(tbl[i].inst, tbl[i].ct, tbl[i].pt, 0, 0, d1);
    end

    // Starts during an operation are ignored; start right after DONE is taken.
    set_key(KEY_F);
    run_op(0, CT_F, PT_F, 5, 21, d1);
    run_op(0, CT_F, PT_F, 0, 0, d2);
    chk("b2b_done_gap", 128'(d2 - d1), 128'd23);

    // Synchronous reset in the middle of a block.
    start_s[0] = 1'b1;
    ct_s[0]    = CT_F;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset(0);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s[0]) dn++;
    end
    chk("no_done_after_rst", 128'(dn), '0);
    run_op(0, CT_F, PT_F, 0, 0, d1);

`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    // Abort mid-block keeps the previous result and produces no done.
    start_s[0] = 1'b1;
    ct_s[0]    = CT_B;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (7) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("abort_busy",     128'(busy_s[0]),     '0);
    chk("abort_done",     128'(done_s[0]),     '0);
    chk("abort_dp_valid", 128'(dp_valid_s[0]), '0);
    chk("abort_pt_keep",  pt_s[0], PT_F);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s[0]) dn++;
    end
    chk("abort_no_done", 128'(dn), '0);
    chk("abort_pt_keep2", pt_s[0], PT_F);

    // Abort together with start in IDLE: the start wins.
    set_key(KEY_B);
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    ct_s[0]    = CT_B;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    dn = 0;
    for (int c = 1; c <= 100 && dn == 0; c++) begin
      if (done_s[0]) dn = c;
      else @(negedge clk);
    end
    chk("abort_start_lat", 128'(dn), 128'd22);
    chk("abort_start_pt",  pt_s[0], PT_B);
    @(negedge clk);
`endif

    // Randomized keys and blocks against the full-block reference.
    for (int t = 0; t < 12; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      exp_pt = aes_dec(ct);
      g = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(g, ct, exp_pt, int'($urandom_range(0, 20)), 0, d1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

Interface
REQ-001 Parameter NR, default 10: number of cipher rounds; the key index runs NR..0.
REQ-002 Parameter DP_LAT, default 1: fixed latency in cycles from dp_valid to a valid dp_out on the inverse-round datapath; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to decrypt ct_in; sampled only in IDLE.
REQ-006 ct_in  input  128  ciphertext block; sampled with an accepted start.
REQ-007 rk_idx  output  4  round-key index driven to the key store.
REQ-008 rk_data  input  128  round key for rk_idx; combinationally valid in the same cycle.
REQ-009 dp_in  output  128  state block presented to the inverse-round datapath.
REQ-010 dp_valid  output  1  issue strobe to the datapath, one cycle per round.
REQ-011 dp_last  output  1  final round; the datapath skips InvMixColumns.
REQ-012 dp_out  input  128  datapath result; valid exactly DP_LAT cycles after dp_valid.
REQ-013 busy  output  1  high from start acceptance until the cycle before done.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pt_out  output  128  plaintext; valid from done and held until the next accepted start.

Function
REQ-016 FSM states SHALL be IDLE, INIT, ISSUE, WAIT and DONE.
REQ-017 IDLE with start=1 SHALL go to INIT, capture ct_in, and set busy; start in any other state SHALL be ignored.
REQ-018 INIT SHALL drive rk_idx=NR and register state = ct_in ^ rk_data; round counter r SHALL be set to NR-1; next state is ISSUE.
REQ-019 ISSUE SHALL assert dp_valid for exactly one cycle, drive dp_in=state and rk_idx=r, and set dp_last=1 only when r=0; next state is WAIT.
REQ-020 dp_in, rk_idx and dp_last SHALL hold stable from ISSUE through the end of WAIT.
REQ-021 WAIT SHALL last DP_LAT cycles, counted by a 3-bit latency counter; on the last WAIT cycle, state SHALL capture dp_out.
REQ-022 After capture, if r=0 the FSM SHALL go to DONE; otherwise r SHALL decrement and the FSM SHALL go to ISSUE.
REQ-023 DONE SHALL assert done=1 and busy=0, load pt_out=state, and return to IDLE the next cycle.
REQ-024 Latency from the start-sampling edge (cycle 0) to the done pulse SHALL be 2 + (NR)*(DP_LAT+1) cycles; this is 22 cycles for the defaults.
REQ-025 Back-to-back operation: start in the cycle after DONE SHALL be accepted, so throughput is one block per 3 + NR*(DP_LAT+1) cycles.
REQ-026 rk_idx SHALL read 0 in IDLE and DONE; dp_valid SHALL be 0 outside ISSUE.

Reset
REQ-027 rst=1 SHALL force IDLE on the next edge and override start, including the abort input when present.
REQ-028 Reset values SHALL be: busy=0, done=0, dp_valid=0, dp_last=0, rk_idx=0, dp_in=0, pt_out=0, internal state=0, r=0, latency counter=0.
REQ-029 Reset mid-operation SHALL discard the block with no done pulse; any dp_out still in flight SHALL be ignored.

Configuration
REQ-030 Macro AES_INV_ROUND_CTRL_ABORT_EN defined: the block SHALL add a 1-bit input abort.
REQ-031 With the macro defined, abort=1 in INIT, ISSUE or WAIT SHALL return the FSM to IDLE next cycle, with busy=0, no done pulse, and pt_out unchanged.
REQ-032 With the macro defined, abort SHALL be ignored in IDLE and DONE; abort and start in the same IDLE cycle SHALL accept the start.
REQ-033 Macro AES_INV_ROUND_CTRL_ABORT_EN undefined: the abort port SHALL be absent and a started block SHALL always complete.

Verification
REQ-034 Setup: FIPS-197 key 000102030405060708090a0b0c0d0e0f in the bench key store with a behavioural inverse-round model; ct_in=69c4e0d86a7b0430d8cdb78070b4c55a and start -> done at cycle 22, pt_out=00112233445566778899aabbccddeeff.
REQ-035 Same vector with DP_LAT=3 -> done at cycle 42 and the same pt_out; dp_in and rk_idx stable across each WAIT; rk_idx sequence 10,9,...,0.
REQ-036 start pulsed in cycles 5 and 21 during an operation -> both ignored; a second start in the cycle after DONE -> accepted, and the second done arrives 23 cycles after the first.
REQ-037 rst asserted at cycle 10 -> all outputs at reset values next cycle and no done; a fresh start then decrypts correctly.
REQ-038 With AES_INV_ROUND_CTRL_ABORT_EN: abort at cycle 8 -> IDLE next cycle, busy=0, no done, and pt_out keeps the previous result.
